exec_mdu_ctrl: RTL and testbench
================================

EXEC_MDU_CTRL -- requirements
Module: exec_mdu_ctrl

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: the single clock. All state updates on the rising edge.
REQ-002 SHALL provide `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL provide `start_Ex`, input, 1 bit: an MDU instruction is present in the Ex stage. Held high for as long as the instruction sits in Ex.
REQ-004 SHALL provide `MDOp_Ex`, input, 3 bits, with this encoding:
- 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
- 100 MTHI, 101 MTLO
- 11x: no operation
REQ-005 SHALL provide `busA_Ex` and `busB_Ex`, inputs, 32 bits each: post-bypass operands. A is the multiplicand or dividend; B is the multiplier or divisor.
REQ-006 SHALL provide `flush`, input, 1 bit: cancels any in-flight operation.
REQ-007 SHALL provide `stall_Ex`, output, 1 bit: freezes the IF/ID/Ex pipeline registers.
REQ-008 SHALL provide `busy`, output, 1 bit: high when the FSM is not in IDLE.
REQ-009 SHALL provide `done`, output, 1 bit: one-cycle pulse after HI/LO commit.
REQ-010 SHALL provide `div_zero`, output, 1 bit: one-cycle pulse, concurrent with `done`, for DIV/DIVU with B==0.
REQ-011 SHALL provide `HI` and `LO`, outputs, 32 bits each: architectural HI/LO registers.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and FIX.
REQ-013 SHALL handle an IDLE request as follows:
- Condition: IDLE, `start_Ex`=1, op in 000-011, `done`=0.
- At the next edge (E0): latch operand magnitudes (absolute value for signed ops, raw for unsigned), latch the sign flags, cnt=0, go to RUN.
REQ-014 SHALL perform one iteration per RUN cycle and increment the 5-bit cnt. After 32 iterations (edge E32), go to FIX.
- Multiply: radix-2 shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
REQ-015 SHALL, at the FIX edge (E33), write HI/LO, go to IDLE and set `done`=1 for exactly one cycle. Total latency from acceptance to commit is 33 cycles.
REQ-016 SHALL apply these signed corrections at FIX:
- Product: negated (64-bit two's complement) if the operand signs differ.
- Quotient: negated if the signs differ.
- Remainder: takes the sign of the dividend.
REQ-017 SHALL write results as follows:
- Multiply: HI=product[63:32], LO=product[31:0].
- Divide: LO=quotient, HI=remainder.
REQ-018 SHALL, for a divide with B==0, still take the full 33 cycles, then commit LO=32'hFFFF_FFFF and HI=A (original signed value) and pulse `div_zero`.
REQ-019 SHALL produce, for DIV of 0x8000_0000 by 0xFFFF_FFFF, LO=0x8000_0000 and HI=0 with no special-casing.
REQ-020 SHALL drive `stall_Ex` = (IDLE & `start_Ex` & op in 000-011 & ~`done`) | RUN | FIX. This is combinational, so the requesting instruction stalls in its first Ex cycle.
REQ-021 SHALL ignore `start_Ex` while `done`=1 and keep `stall_Ex` low in that cycle, so the completed instruction leaves Ex without restarting.
REQ-022 SHALL handle MTHI/MTLO in IDLE with `start_Ex`=1 by writing HI (or LO) = `busA_Ex` at the next edge, with no stall and no `done` pulse.
REQ-023 SHALL ignore `start_Ex` and `MDOp_Ex` while in RUN or FIX.
REQ-024 SHALL handle `flush`=1 synchronously, with priority over all other inputs:
- Go to IDLE, cnt=0, `done`=0, `div_zero`=0.
- HI/LO unchanged; no commit or write occurs that edge, including a pending FIX commit or MTHI/MTLO.
REQ-025 SHALL drive `busy`=0 only in IDLE. `busy` is registered state, not combinational on `start_Ex`.
REQ-026 SHALL keep HI/LO stable except at a FIX commit or an MTHI/MTLO write.

Reset
REQ-027 SHALL, while `rst`=1, immediately force: state=IDLE, cnt=0, HI=0, LO=0, `done`=0, `div_zero`=0, `busy`=0, all operand, accumulator and sign registers = 0.
REQ-028 SHALL force `stall_Ex`=0 while `rst`=1 and on the first edge after release unless a new request is present. Reset mid-RUN abandons the operation with no commit.

Verification
REQ-029 SHALL cover MULT A=0xFFFF_FFFD (-3), B=5:
- `stall_Ex` high for 34 cycles.
- Then HI=0xFFFF_FFFF, LO=0xFFFF_FFF1, `done` pulse.
- `stall_Ex`=0 in the `done` cycle.
REQ-030 SHALL cover the divide results:
- DIVU 100/7: LO=14, HI=2.
- DIV -7/2: LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- MULTU 0xFFFF_FFFF*0xFFFF_FFFF: HI=0xFFFF_FFFE, LO=1.
REQ-031 SHALL cover DIVU 9/0: after 33 cycles LO=0xFFFF_FFFF and HI=9, with `div_zero` and `done` both pulsing once.
REQ-032 SHALL cover `flush` at RUN cycle 10 with prior HI=0x1234, LO=0x5678:
- Next cycle: `busy`=0, `stall_Ex`=0.
- HI/LO still 0x1234/0x5678; no `done`.
REQ-033 SHALL cover `rst` asserted at RUN cycle 20: all outputs 0 immediately, and no commit after release.
REQ-034 SHALL cover MTHI A=0xCAFE_0001 in IDLE: HI=0xCAFE_0001 next cycle, `stall_Ex`=0, LO unchanged.

Source files
------------

// File: rtl/exec_mdu_ctrl_if.sv
// Ex-stage handshake and result bundle between the pipeline and the
// iterative multiply/divide unit.
interface exec_mdu_ctrl_if;
    logic        start_Ex;
    logic [2:0]  MDOp_Ex;
    logic [31:0] busA_Ex;
    logic [31:0] busB_Ex;
    logic        flush;
    logic        stall_Ex;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start_Ex, MDOp_Ex, busA_Ex, busB_Ex, flush,
        input  stall_Ex, busy, done, div_zero, HI, LO
    );

    modport slave (
        input  start_Ex, MDOp_Ex, busA_Ex, busB_Ex, flush,
        output stall_Ex, busy, done, div_zero, HI, LO
    );
endinterface

// File: rtl/exec_mdu_ctrl.sv
// Iterative MDU: 32-cycle shift-add multiply / restoring divide on operand
// magnitudes, sign fix-up and HI/LO commit in a final FIX cycle.
module exec_mdu_ctrl (
    input  logic           clk,
    input  logic           rst,
    exec_mdu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_ma;
    logic [31:0] r_mb;
    logic [63:0] r_acc;
    logic        r_sa;
    logic        r_sb;
    logic        r_div;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dz;

    logic        w_idle;
    logic        w_req;
    logic        w_mt;
    logic        w_signed;
    logic        w_nega;
    logic        w_negb;
    logic [31:0] w_absa;
    logic [31:0] w_absb;

    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = w_idle & bus.start_Ex & ~bus.MDOp_Ex[2] & ~r_done;
    assign w_mt     = w_idle & bus.start_Ex & ~r_done
                    & (bus.MDOp_Ex[2:1] == 2'b10);
    assign w_signed = ~bus.MDOp_Ex[0];
    assign w_nega   = w_signed & bus.busA_Ex[31];
    assign w_negb   = w_signed & bus.busB_Ex[31];
    assign w_absa   = w_nega ? -bus.busA_Ex : bus.busA_Ex;
    assign w_absb   = w_negb ? -bus.busB_Ex : bus.busB_Ex;

    // Multiply step: add multiplicand into upper half, shift right by one.
    logic [32:0] w_msum;
    assign w_msum = {1'b0, r_acc[63:32]}
                  + (r_mb[0] ? {1'b0, r_ma} : 33'd0);

    // Divide step: acc holds {remainder, dividend/quotient}.
    logic [32:0] w_dsh;
    logic        w_qbit;
    logic [31:0] w_dsub;
    logic [31:0] w_drem;
    assign w_dsh  = r_acc[63:31];
    assign w_qbit = (w_dsh >= {1'b0, r_mb});
    assign w_dsub = w_dsh[31:0] - r_mb;
    assign w_drem = w_qbit ? w_dsub : w_dsh[31:0];

    logic [63:0] w_pfix;
    logic [31:0] w_qfix;
    logic [31:0] w_rfix;
    logic        w_dz;
    assign w_pfix = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_qfix = (r_sa ^ r_sb) ? -r_acc[31:0] : r_acc[31:0];
    assign w_rfix = r_sa ? -r_acc[63:32] : r_acc[63:32];
    assign w_dz   = r_div & (r_mb == 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else if (bus.flush)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = S_RUN;
            S_RUN:  if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = ~w_idle;
        bus.stall_Ex = ~rst & (w_req | ~w_idle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 5'd0;
            r_ma   <= 32'd0;
            r_mb   <= 32'd0;
            r_acc  <= 64'd0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_div  <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else if (bus.flush) begin
            r_cnt  <= 5'd0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_ma  <= w_absa;
                        r_mb  <= w_absb;
                        r_sa  <= w_nega;
                        r_sb  <= w_negb;
                        r_div <= bus.MDOp_Ex[1];
                        r_cnt <= 5'd0;
                        r_acc <= bus.MDOp_Ex[1] ? {32'd0, w_absa} : 64'd0;
                    end else if (w_mt) begin
                        if (bus.MDOp_Ex[0])
                            r_lo <= bus.busA_Ex;
                        else
                            r_hi <= bus.busA_Ex;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_div) begin
                        r_acc <= {w_drem, r_acc[30:0], w_qbit};
                    end else begin
                        r_acc <= {w_msum, r_acc[31:1]};
                        r_mb  <= r_mb >> 1;
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    r_dz   <= w_dz;
                    if (r_div) begin
                        r_lo <= w_dz ? 32'hFFFF_FFFF : w_qfix;
                        r_hi <= w_rfix;
                    end else begin
                        r_lo <= w_pfix[31:0];
                        r_hi <= w_pfix[63:32];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done     = r_done;
    assign bus.div_zero = r_dz;
    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
endmodule

// File: tb/tb_exec_mdu_ctrl.sv
// Directed bench for exec_mdu_ctrl: latency, signed/unsigned results,
// divide-by-zero, MTHI/MTLO, flush and mid-operation reset.
module tb_exec_mdu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exec_mdu_ctrl_if m ();

    exec_mdu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        int n;
        m.start_Ex = 1'b1;
        m.MDOp_Ex  = op;
        m.busA_Ex  = a;
        m.busB_Ex  = b;
        #1;
        n = 0;
        while (m.stall_Ex === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'd34);
        chk({tag, " done"}, {31'd0, m.done}, 32'd1);
        chk({tag, " div_zero"}, {31'd0, m.div_zero}, {31'd0, edz});
        chk({tag, " HI"}, m.HI, ehi);
        chk({tag, " LO"}, m.LO, elo);
        chk({tag, " stall_in_done"}, {31'd0, m.stall_Ex}, 32'd0);
        step();
        chk({tag, " done_clear"}, {31'd0, m.done}, 32'd0);
        chk({tag, " no_restart"}, {31'd0, m.busy}, 32'd0);
        m.start_Ex = 1'b0;
    endtask

    task automatic mt(input string tag, input logic lo_sel,
                      input logic [31:0] a);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = m.HI;
        lo0 = m.LO;
        m.start_Ex = 1'b1;
        m.MDOp_Ex  = {2'b10, lo_sel};
        m.busA_Ex  = a;
        #1;
        chk({tag, " stall"}, {31'd0, m.stall_Ex}, 32'd0);
        step();
        m.start_Ex = 1'b0;
        chk({tag, " HI"}, m.HI, lo_sel ? hi0 : a);
        chk({tag, " LO"}, m.LO, lo_sel ? a : lo0);
        chk({tag, " done"}, {31'd0, m.done}, 32'd0);
    endtask

    initial begin
        int dcnt;
        m.start_Ex = 1'b1;
        m.MDOp_Ex  = 3'b000;
        m.busA_Ex  = 32'd1;
        m.busB_Ex  = 32'd1;
        m.flush    = 1'b0;
        #1;
        chk("rst stall", {31'd0, m.stall_Ex}, 32'd0);
        chk("rst busy", {31'd0, m.busy}, 32'd0);
        chk("rst HI", m.HI, 32'd0);
        chk("rst LO", m.LO, 32'd0);
        m.start_Ex = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst busy", {31'd0, m.busy}, 32'd0);

        mt("mthi", 1'b0, 32'hCAFE_0001);

        run_op("mult", 3'b000, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_negb", 3'b010, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'd1, 1'b0);
        run_op("divu_zero", 3'b011, 32'd9, 32'd0,
               32'd9, 32'hFFFF_FFFF, 1'b1);
        run_op("div_zero_neg", 3'b010, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0);

        mt("mthi2", 1'b0, 32'h0000_1234);
        mt("mtlo", 1'b1, 32'h0000_5678);

        m.start_Ex = 1'b1;
        m.MDOp_Ex  = 3'b000;
        m.busA_Ex  = 32'd3;
        m.busB_Ex  = 32'd4;
        step();
        for (int i = 0; i < 9; i++) step();
        chk("flush busy_before", {31'd0, m.busy}, 32'd1);
        m.flush    = 1'b1;
        m.start_Ex = 1'b0;
        step();
        m.flush = 1'b0;
        chk("flush busy", {31'd0, m.busy}, 32'd0);
        chk("flush stall", {31'd0, m.stall_Ex}, 32'd0);
        chk("flush HI", m.HI, 32'h0000_1234);
        chk("flush LO", m.LO, 32'h0000_5678);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (m.done === 1'b1) dcnt++;
            step();
        end
        chk("flush no_done", 32'(dcnt), 32'd0);
        chk("flush HI_late", m.HI, 32'h0000_1234);

        m.start_Ex = 1'b1;
        m.MDOp_Ex  = 3'b011;
        m.busA_Ex  = 32'd100;
        m.busB_Ex  = 32'd7;
        step();
        for (int i = 0; i < 19; i++) step();
        chk("rstrun busy_before", {31'd0, m.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstrun stall", {31'd0, m.stall_Ex}, 32'd0);
        chk("rstrun busy", {31'd0, m.busy}, 32'd0);
        chk("rstrun HI", m.HI, 32'd0);
        chk("rstrun LO", m.LO, 32'd0);
        chk("rstrun flags", {30'd0, m.done, m.div_zero}, 32'd0);
        m.start_Ex = 1'b0;
        step();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (m.done === 1'b1) dcnt++;
            step();
        end
        chk("rstrun no_done", 32'(dcnt), 32'd0);
        chk("rstrun HI_late", m.HI, 32'd0);
        chk("rstrun LO_late", m.LO, 32'd0);
        chk("rstrun busy_late", {31'd0, m.busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
